alu_div: RTL



---
 rtl/alu_div_if.sv | 25 ++
 rtl/alu_div.sv | 132 +++++++++++++
 2 files changed

// File: rtl/alu_div_if.sv
// Request/response channel between decode and the iterative divider.
// Decode drives the master side; the divider implements the slave side.
interface alu_div_if #(
    parameter int BIT_WIDTH = 32
);
    logic                 in_valid;
    logic                 in_ready;
    logic [1:0]           op;
    logic [BIT_WIDTH-1:0] in1;
    logic [BIT_WIDTH-1:0] in2;
    logic                 out_valid;
    logic                 out_ready;
    logic [BIT_WIDTH-1:0] out;
    logic                 div_zero;

    modport master (
        output in_valid, op, in1, in2, out_ready,
        input  in_ready, out_valid, out, div_zero
    );

    modport slave (
        input  in_valid, op, in1, in2, out_ready,
        output in_ready, out_valid, out, div_zero
    );
endinterface

// File: rtl/alu_div.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU, one quotient bit per cycle.
// Optional ALU_DIV_EARLY_OUT_EN: divide-by-zero and signed overflow bypass CALC/FIXUP.
module alu_div #(
    parameter int BIT_WIDTH = 32
) (
    input  logic      CLK,
    input  logic      nRST,
    input  logic      flush,
    alu_div_if.slave  bus
);
    localparam int             CW         = $clog2(BIT_WIDTH + 1);
    localparam logic [CW-1:0]  COUNT_INIT = CW'(BIT_WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;

    state_t               state, state_nxt;
    logic [BIT_WIDTH-1:0] quo;
    logic [BIT_WIDTH-1:0] rem;
    logic [BIT_WIDTH-1:0] dvs;
    logic [BIT_WIDTH-1:0] result;
    logic [CW-1:0]        count;
    logic                 is_rem, neg_quo, neg_rem, dz;

    logic                 accept, signed_op, in1_neg, in2_neg;
    logic [BIT_WIDTH-1:0] abs1, abs2;
    logic [BIT_WIDTH:0]   rem_shift;
    logic [BIT_WIDTH-1:0] diff;
    logic                 ge;

    assign bus.in_ready  = (state == IDLE) && !flush;
    assign bus.out_valid = (state == DONE);
    assign bus.out       = result;
    assign bus.div_zero  = dz;

    assign accept    = bus.in_valid && bus.in_ready;
    assign signed_op = !bus.op[0];
    assign in1_neg   = signed_op && bus.in1[BIT_WIDTH-1];
    assign in2_neg   = signed_op && bus.in2[BIT_WIDTH-1];
    assign abs1      = in1_neg ? -bus.in1 : bus.in1;
    assign abs2      = in2_neg ? -bus.in2 : bus.in2;

    // The partial remainder stays below the divisor, so the shifted value fits in
    // BIT_WIDTH+1 bits and a successful subtract always lands back in BIT_WIDTH bits.
    assign rem_shift = {rem, quo[BIT_WIDTH-1]};
    assign ge        = rem_shift >= {1'b0, dvs};
    assign diff      = rem_shift[BIT_WIDTH-1:0] - dvs;

`ifdef ALU_DIV_EARLY_OUT_EN
    logic                 special;
    logic [BIT_WIDTH-1:0] special_res;

    assign special     = (bus.in2 == '0) ||
                         (signed_op && bus.in1 == {1'b1, {(BIT_WIDTH-1){1'b0}}} && bus.in2 == '1);
    assign special_res = (bus.in2 == '0) ? (bus.op[1] ? bus.in1 : '1)
                                         : (bus.op[1] ? '0 : bus.in1);
`endif

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of block ordering.
    always_ff @(posedge CLK) begin
        if (!nRST) state <= IDLE;
        else       state <= state_nxt;
    end

    // NOTE: next state gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
`ifdef ALU_DIV_EARLY_OUT_EN
                        state_nxt = special ? DONE : CALC;
`else
                        state_nxt = CALC;
`endif
                    end
                end
                CALC:    if (count == CW'(1)) state_nxt = FIXUP;
                FIXUP:   state_nxt = DONE;
                DONE:    if (bus.out_ready) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            quo     <= '0;
            rem     <= '0;
            dvs     <= '0;
            result  <= '0;
            count   <= '0;
            is_rem  <= 1'b0;
            neg_quo <= 1'b0;
            neg_rem <= 1'b0;
            dz      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        quo     <= abs1;
                        dvs     <= abs2;
                        rem     <= '0;
                        count   <= COUNT_INIT;
                        is_rem  <= bus.op[1];
                        // A zero divisor must yield all ones for DIV, so its quotient is never negated.
                        neg_quo <= (in1_neg ^ in2_neg) && (bus.in2 != '0);
                        neg_rem <= in1_neg;
                        dz      <= (bus.in2 == '0);
`ifdef ALU_DIV_EARLY_OUT_EN
                        result  <= special_res;
`endif
                    end
                end
                CALC: begin
                    rem   <= ge ? diff : rem_shift[BIT_WIDTH-1:0];
                    quo   <= {quo[BIT_WIDTH-2:0], ge};
                    count <= count - CW'(1);
                end
                FIXUP: begin
                    if (is_rem) result <= neg_rem ? -rem : rem;
                    else        result <= neg_quo ? -quo : quo;
                end
                default: ;
            endcase
        end
    end
endmodule
